// File: rtl/receptor_paridad.sv
// Serial frame receiver for the XOR-parity link: start, DATA_BITS data (LSB first), parity, stop.
// Define PARIDAD_IMPAR_EN for odd parity; the default build checks even parity.
module receptor_paridad #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE,
        S_BREAK
    } state_t;

    state_t                 state_q;
    logic                   rx_meta_q;
    logic                   rx_s_q;
    logic [CW-1:0]          cnt_q;
    logic [BW-1:0]          bit_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]   shift_d;
    logic                   par_q;
    logic                   stop_q;
    logic [DATA_BITS-1:0]   data_q;
    logic                   valid_q;
    logic                   perr_q;
    logic                   ferr_q;
    logic                   busy_q;
    logic                   perr_d;
    logic                   cnt_hit;

    // Two-flop synchronizer; the line idles high so reset preloads ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    generate
        if (DATA_BITS == 1) begin : g_shift_one
            assign shift_d = rx_s_q;
        end else begin : g_shift_many
            assign shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
        end
    endgenerate

    always_comb begin
        perr_d = (^shift_q) ^ par_q;
`ifdef PARIDAD_IMPAR_EN
        perr_d = ~((^shift_q) ^ par_q);
`endif
    end

    // The start bit is sampled half a period in; every later sample is a full period apart.
    always_comb begin
        cnt_hit = (cnt_q == BIT_LAST);
        if (state_q == S_START) begin
            cnt_hit = (cnt_q == HALF_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            stop_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    bit_q <= '0;
                    if (!rx_s_q) begin
                        state_q <= S_START;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt_hit) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_hit) begin
                        cnt_q   <= '0;
                        shift_q <= shift_d;
                        if (bit_q == DATA_LAST) begin
                            state_q <= S_PARITY;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (cnt_hit) begin
                        cnt_q   <= '0;
                        par_q   <= rx_s_q;
                        state_q <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt_hit) begin
                        cnt_q   <= '0;
                        stop_q  <= rx_s_q;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    valid_q <= 1'b1;
                    data_q  <= shift_q;
                    perr_q  <= perr_d;
                    ferr_q  <= ~stop_q;
                    if (stop_q) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= S_BREAK;
                    end
                end
                S_BREAK: begin
                    // A line held low must go high before another start can be seen.
                    if (rx_s_q) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = busy_q;

endmodule
